// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file with atomic ops, counters, vectored traps and prioritised interrupts
module csr_unit #(
    parameter int          NUM_FAST_IRQ = 4,
    parameter int          COUNTER_W    = 64,
    parameter bit          VECTORED_EN  = 1'b1,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csr_req,
    input  logic [1:0]              csr_op,
    input  logic [11:0]             csr_addr,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    csr_illegal,
    input  logic                    instr_retire,
    input  logic                    irq_ext,
    input  logic                    irq_timer,
    input  logic                    irq_soft,
    input  logic [NUM_FAST_IRQ-1:0] irq_fast,
    output logic                    irq_req,
    input  logic                    irq_ack,
    input  logic [31:0]             irq_pc,
    input  logic                    exc_valid,
    input  logic [4:0]              exc_cause,
    input  logic [31:0]             exc_pc,
    input  logic [31:0]             exc_tval,
    input  logic                    mret,
    output logic [31:0]             trap_vector,
    output logic [31:0]             mepc_o,
    output logic                    mie_global
);

    localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'd1 << NUM_FAST_IRQ) - 32'd1) << 16);
    localparam logic [COUNTER_W-1:0] CNT_ONE = {{(COUNTER_W-1){1'b0}}, 1'b1};

    logic                 mstat_mie, mstat_mpie;
    logic [31:0]          mie_r, mip_r, mscratch, mepc, mcause, mtval;
    logic [29:0]          mtvec_base;
    logic                 mtvec_mode;
    logic                 inhibit_cy, inhibit_ir;
    logic [COUNTER_W-1:0] mcycle, minstret;
    logic                 irq_req_r;

    logic [31:0] irq_in, pending;
    logic [4:0]  irq_code;
    logic        irq_any;
    logic [63:0] mcycle64, minstret64;
    logic        implemented, is_write, wr_en, ack_take;
    logic [31:0] wval;

    always_comb begin
        irq_in = '0;
        irq_in[3]  = irq_soft;
        irq_in[7]  = irq_timer;
        irq_in[11] = irq_ext;
        irq_in[16 +: NUM_FAST_IRQ] = irq_fast;
    end

    assign pending = mip_r & mie_r;
    assign irq_any = |pending;

    // Later assignments win: fast lines (lowest index last), then MTI, MSI, MEI.
    always_comb begin
        irq_code = 5'd0;
        for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
            if (pending[16 + i]) irq_code = 5'(16 + i);
        end
        if (pending[7])  irq_code = 5'd7;
        if (pending[3])  irq_code = 5'd3;
        if (pending[11]) irq_code = 5'd11;
    end

    assign mcycle64   = 64'(mcycle);
    assign minstret64 = 64'(minstret);

    always_comb begin
        csr_rdata   = '0;
        implemented = 1'b1;
        case (csr_addr)
            12'h300: csr_rdata = {24'b0, mstat_mpie, 3'b0, mstat_mie, 3'b0};
            12'h301: csr_rdata = 32'h4000_0100;
            12'h304: csr_rdata = mie_r;
            12'h305: csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
            12'h310: csr_rdata = '0;
            12'h320: csr_rdata = {29'b0, inhibit_ir, 1'b0, inhibit_cy};
            12'h340: csr_rdata = mscratch;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            12'h343: csr_rdata = mtval;
            12'h344: csr_rdata = mip_r;
            12'hB00: csr_rdata = mcycle64[31:0];
            12'hB80: csr_rdata = mcycle64[63:32];
            12'hB02: csr_rdata = minstret64[31:0];
            12'hB82: csr_rdata = minstret64[63:32];
            12'hF11, 12'hF12, 12'hF13, 12'hF14: csr_rdata = '0;
            default: implemented = 1'b0;
        endcase
    end

    assign is_write    = (csr_op == 2'b01) || (csr_op[1] && (csr_wdata != 32'd0));
    assign csr_illegal = csr_req && (csr_op != 2'b00) &&
                         (!implemented || ((csr_addr[11:10] == 2'b11) && is_write));

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    // Traps and mret pre-empt any CSR write issued in the same cycle.
    assign ack_take = irq_ack && irq_req_r && !exc_valid;
    assign wr_en    = csr_req && (csr_op != 2'b00) && is_write && !csr_illegal &&
                      !exc_valid && !ack_take && !mret;

    always_ff @(posedge clk) begin
        if (rst) begin
            mstat_mie  <= 1'b1;
            mstat_mpie <= 1'b0;
            mie_r      <= '0;
            mip_r      <= '0;
            mscratch   <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mtval      <= '0;
            mtvec_base <= MTVEC_RESET[31:2];
            mtvec_mode <= VECTORED_EN && (MTVEC_RESET[1:0] == 2'b01);
            inhibit_cy <= 1'b0;
            inhibit_ir <= 1'b0;
            irq_req_r  <= 1'b0;
        end else begin
            mip_r     <= irq_in;
            irq_req_r <= ack_take ? 1'b0 : (mstat_mie && irq_any);
            if (exc_valid) begin
                mstat_mpie <= mstat_mie;
                mstat_mie  <= 1'b0;
                mepc       <= exc_pc & ~32'h3;
                mcause     <= {27'b0, exc_cause};
                mtval      <= exc_tval;
            end else if (ack_take) begin
                mstat_mpie <= mstat_mie;
                mstat_mie  <= 1'b0;
                mepc       <= irq_pc & ~32'h3;
                mcause     <= {1'b1, 26'b0, irq_code};
                mtval      <= '0;
            end else if (mret) begin
                mstat_mie  <= mstat_mpie;
                mstat_mpie <= 1'b1;
            end else if (wr_en) begin
                case (csr_addr)
                    12'h300: begin
                        mstat_mie  <= wval[3];
                        mstat_mpie <= wval[7];
                    end
                    12'h304: mie_r <= wval & MIE_MASK;
                    12'h305: begin
                        mtvec_base <= wval[31:2];
                        mtvec_mode <= VECTORED_EN && (wval[1:0] == 2'b01);
                    end
                    12'h320: begin
                        inhibit_cy <= wval[0];
                        inhibit_ir <= wval[2];
                    end
                    12'h340: mscratch <= wval;
                    12'h341: mepc     <= wval & ~32'h3;
                    12'h342: mcause   <= wval;
                    12'h343: mtval    <= wval;
                    default: ;
                endcase
            end
        end
    end

    // A write to one counter half replaces that cycle's increment; the other half holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_en && csr_addr == 12'hB00)
                mcycle <= {mcycle[COUNTER_W-1:32], wval};
            else if (wr_en && csr_addr == 12'hB80)
                mcycle <= {wval[COUNTER_W-33:0], mcycle[31:0]};
            else if (!inhibit_cy)
                mcycle <= mcycle + CNT_ONE;

            if (wr_en && csr_addr == 12'hB02)
                minstret <= {minstret[COUNTER_W-1:32], wval};
            else if (wr_en && csr_addr == 12'hB82)
                minstret <= {wval[COUNTER_W-33:0], minstret[31:0]};
            else if (instr_retire && !inhibit_ir)
                minstret <= minstret + CNT_ONE;
        end
    end

    assign trap_vector = (mtvec_mode && irq_any && !exc_valid)
                       ? {mtvec_base, 2'b00} + {25'b0, irq_code, 2'b00}
                       : {mtvec_base, 2'b00};
    assign mepc_o      = mepc;
    assign mie_global  = mstat_mie;
    assign irq_req     = irq_req_r;

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - scoreboard bench for csr_unit with directed vectors
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire;
    logic        irq_ext, irq_timer, irq_soft;
    logic [3:0]  irq_fast;
    logic        irq_req;
    logic        irq_ack;
    logic [31:0] irq_pc;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        mret;
    logic [31:0] trap_vector, mepc_o;
    logic        mie_global;

    csr_unit #(
        .NUM_FAST_IRQ(4),
        .COUNTER_W   (64),
        .VECTORED_EN (1'b1),
        .MTVEC_RESET (32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instr_retire(instr_retire),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft), .irq_fast(irq_fast),
        .irq_req(irq_req), .irq_ack(irq_ack), .irq_pc(irq_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret(mret), .trap_vector(trap_vector), .mepc_o(mepc_o), .mie_global(mie_global)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
        bit          chk;
        string       name;
    } csr_exp_t;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } probe_t;

    localparam int P_IRQ_REQ = 0;
    localparam int P_TVEC    = 1;
    localparam int P_MEPC    = 2;
    localparam int P_MIE     = 3;

    csr_exp_t csr_q[$];
    probe_t   probe_q[$];
    int       probe_cnt = 0;
    int       vectors = 0;
    int       miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: consumes one expectation per presented CSR access and per queued probe.
    initial begin
        forever begin
            @(negedge clk);
            if (csr_req) begin
                if (csr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL csr_q underflow: got access to 0x%03h expected none", csr_addr);
                end else begin
                    csr_exp_t e;
                    e = csr_q.pop_front();
                    check({e.name, ".illegal"}, 32'(csr_illegal), 32'(e.ill));
                    if (e.chk) check(e.name, csr_rdata, e.rdata);
                end
            end
            for (int k = 0; k < probe_cnt; k++) begin
                if (probe_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL probe_q underflow: got probe expected none");
                end else begin
                    probe_t p;
                    logic [31:0] act;
                    p = probe_q.pop_front();
                    case (p.sel)
                        P_IRQ_REQ: act = 32'(irq_req);
                        P_TVEC:    act = trap_vector;
                        P_MEPC:    act = mepc_o;
                        default:   act = 32'(mie_global);
                    endcase
                    check(p.name, act, p.val);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        probe_cnt = 0;
        csr_req   = 1'b0;
        csr_op    = 2'b00;
        irq_ack   = 1'b0;
        exc_valid = 1'b0;
        mret      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic probe(input int sel, input logic [31:0] val, input string name);
        probe_t p;
        p.sel = sel;
        p.val = val;
        p.name = name;
        probe_q.push_back(p);
        probe_cnt++;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input logic ill, input bit chk, input string name);
        csr_exp_t e;
        e.rdata = exp;
        e.ill   = ill;
        e.chk   = chk;
        e.name  = name;
        csr_q.push_back(e);
        csr_req   = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        step();
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
        csr(2'b10, addr, 32'd0, exp, 1'b0, 1'b1, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; csr_req = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        instr_retire = 0; irq_ext = 0; irq_timer = 0; irq_soft = 0; irq_fast = 0;
        irq_ack = 0; irq_pc = 0; exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; mret = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state and free-running mcycle (cycle 0 after reset reads 0)
        probe(P_IRQ_REQ, 32'd0, "reset.irq_req");
        probe(P_MIE, 32'd1, "reset.mie_global");
        probe(P_TVEC, 32'd0, "reset.trap_vector");
        rd(12'hB00, 32'd0, "reset.mcycle");
        rd(12'h300, 32'h8, "reset.mstatus");
        idle(8);
        rd(12'hB00, 32'd10, "mcycle.after10");
        csr(2'b10, 12'h320, 32'd1, 32'd0, 1'b0, 1'b1, "rs.mcountinhibit");
        rd(12'hB00, 32'd12, "mcycle.frozen_a");
        idle(3);
        rd(12'hB00, 32'd12, "mcycle.frozen_b");
        rd(12'h301, 32'h4000_0100, "misa");
        csr(2'b01, 12'h301, 32'd0, 32'h4000_0100, 1'b0, 1'b1, "rw.misa");
        rd(12'h301, 32'h4000_0100, "misa.after_write");
        rd(12'h310, 32'd0, "mstatush");

        // external interrupt, ack and mret
        csr(2'b10, 12'h304, 32'h800, 32'd0, 1'b0, 1'b1, "rs.mie");
        irq_ext = 1'b1;
        probe(P_IRQ_REQ, 32'd0, "ext.irq_req_t0");
        step();
        probe(P_IRQ_REQ, 32'd0, "ext.irq_req_t1");
        step();
        probe(P_IRQ_REQ, 32'd1, "ext.irq_req_t2");
        probe(P_TVEC, 32'd0, "ext.trap_vector");
        irq_ack = 1'b1;
        irq_pc  = 32'h104;
        step();
        irq_ext = 1'b0;
        probe(P_IRQ_REQ, 32'd0, "ack.irq_req_drop");
        probe(P_MEPC, 32'h104, "ack.mepc_o");
        probe(P_MIE, 32'd0, "ack.mie_global");
        rd(12'h342, 32'h8000_000B, "ack.mcause");
        rd(12'h341, 32'h104, "ack.mepc");
        rd(12'h300, 32'h80, "ack.mstatus");
        rd(12'h343, 32'd0, "ack.mtval");
        mret = 1'b1;
        probe(P_MEPC, 32'h104, "mret.mepc_o");
        step();
        probe(P_MIE, 32'd1, "mret.mie_global");
        rd(12'h300, 32'h88, "mret.mstatus");

        // vectored mtvec: MTI beats fast line 0
        csr(2'b01, 12'h305, 32'h1001, 32'd0, 1'b0, 1'b1, "rw.mtvec");
        csr(2'b01, 12'h304, 32'h10080, 32'h800, 1'b0, 1'b1, "rw.mie");
        irq_timer = 1'b1;
        irq_fast  = 4'b0001;
        idle(2);
        probe(P_TVEC, 32'h101C, "vec.trap_vector");
        probe(P_IRQ_REQ, 32'd1, "vec.irq_req");
        rd(12'h344, 32'h10080, "vec.mip");
        irq_timer = 1'b0;
        irq_fast  = 4'b0000;
        csr(2'b01, 12'h304, 32'd0, 32'h10080, 1'b0, 1'b1, "rw.mie_clear");
        rd(12'h305, 32'h1001, "mtvec.vectored");
        csr(2'b01, 12'h305, 32'h2003, 32'h1001, 1'b0, 1'b1, "rw.mtvec_mode3");
        rd(12'h305, 32'h2000, "mtvec.mode3_to_0");

        // exception with simultaneous ack and CSR write
        probe(P_TVEC, 32'h2000, "exc.trap_vector");
        exc_valid = 1'b1;
        exc_cause = 5'd2;
        exc_pc    = 32'h203;
        exc_tval  = 32'hDEAD;
        irq_ack   = 1'b1;
        irq_pc    = 32'h500;
        csr(2'b01, 12'h340, 32'h55, 32'd0, 1'b0, 1'b1, "exc.mscratch_write");
        rd(12'h342, 32'd2, "exc.mcause");
        rd(12'h341, 32'h200, "exc.mepc");
        rd(12'h343, 32'hDEAD, "exc.mtval");
        rd(12'h340, 32'd0, "exc.mscratch");
        rd(12'h300, 32'h80, "exc.mstatus");

        // WARL masks
        csr(2'b01, 12'h341, 32'h307, 32'h200, 1'b0, 1'b1, "rw.mepc");
        rd(12'h341, 32'h304, "mepc.warl");
        csr(2'b01, 12'h300, 32'hFFFF_FFFF, 32'h80, 1'b0, 1'b1, "rw.mstatus");
        rd(12'h300, 32'h88, "mstatus.warl");
        csr(2'b01, 12'h304, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, "rw.mie_all");
        rd(12'h304, 32'h000F_0888, "mie.warl");
        csr(2'b01, 12'h344, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, "rw.mip");
        rd(12'h344, 32'd0, "mip.readonly");
        csr(2'b01, 12'h320, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, "rw.mcountinhibit");
        rd(12'h320, 32'd5, "mcountinhibit.warl");

        // access faults
        csr(2'b01, 12'hF11, 32'h1234, 32'd0, 1'b1, 1'b1, "rw.mvendorid");
        rd(12'hF11, 32'd0, "mvendorid.read");
        csr(2'b10, 12'h7C0, 32'd0, 32'd0, 1'b1, 1'b1, "rd.unimpl");
        csr(2'b11, 12'hB00, 32'd0, 32'd0, 1'b0, 1'b0, "rc0.mcycle");

        // minstret: inhibited, then counting
        instr_retire = 1'b1;
        idle(3);
        instr_retire = 1'b0;
        rd(12'hB02, 32'd0, "minstret.inhibited");
        csr(2'b11, 12'h320, 32'd5, 32'd5, 1'b0, 1'b1, "rc.mcountinhibit");
        instr_retire = 1'b1;
        idle(3);
        instr_retire = 1'b0;
        rd(12'hB02, 32'd3, "minstret.count");
        rd(12'hB82, 32'd0, "minstreth");

        // mcycle low-half wrap into mcycleh
        csr(2'b01, 12'hB80, 32'd0, 32'd0, 1'b0, 1'b1, "rw.mcycleh");
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "rw.mcycle");
        rd(12'hB00, 32'hFFFF_FFFF, "wrap.mcycle_pre");
        rd(12'hB80, 32'd1, "wrap.mcycleh");
        rd(12'hB00, 32'd1, "wrap.mcycle_post");

        // reset mid-count
        rst = 1'b1;
        step();
        rst = 1'b0;
        probe(P_IRQ_REQ, 32'd0, "rst2.irq_req");
        rd(12'hB00, 32'd0, "rst2.mcycle");
        rd(12'hB80, 32'd0, "rst2.mcycleh");
        rd(12'hB02, 32'd0, "rst2.minstret");
        rd(12'h300, 32'h8, "rst2.mstatus");
        rd(12'h305, 32'd0, "rst2.mtvec");
        rd(12'h341, 32'd0, "rst2.mepc");
        rd(12'h304, 32'd0, "rst2.mie");

        idle(2);
        check("scoreboard.drained", 32'(csr_q.size() + probe_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised machine-mode CSR file; successor to the single-cause CSR block.
- Adds atomic CSR ops (RW/RS/RC), access checking and prioritised interrupts from standard plus NUM_FAST_IRQ fast lines.
- Adds cycle and retire counters, mtval, vectored mtvec and mret restore.
- Sits beside decode/execute; the pipeline consumes trap_vector, mepc_o and irq_req.

Parameters:
NUM_FAST_IRQ, 4, fast interrupt lines, mip/mie bits 16..16+N-1 (1..16)
COUNTER_W, 64, implemented width of mcycle/minstret (33..64); unimplemented upper bits read 0
VECTORED_EN, 1, 1 = mtvec mode 1 (vectored) legal; 0 = mode forced to 0
MTVEC_RESET, 32'h00000000, reset value of mtvec

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
csr_req  in  1  CSR instruction valid this cycle
csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no-op
csr_addr  in  12  CSR address
csr_wdata  in  32  rs1/zimm operand
csr_rdata  out  32  old CSR value, combinational
csr_illegal  out  1  access fault, combinational
instr_retire  in  1  one instruction retired
irq_ext / irq_timer / irq_soft  in  1 each  level interrupt inputs
irq_fast  in  NUM_FAST_IRQ  fast interrupt levels
irq_req  out  1  interrupt pending and enabled
irq_ack  in  1  pipeline takes the interrupt
irq_pc  in  32  PC saved on interrupt
exc_valid  in  1  synchronous exception
exc_cause  in  5  exception code
exc_pc  in  32  faulting PC
exc_tval  in  32  trap value
mret  in  1  mret executes
trap_vector  out  32  trap target PC
mepc_o  out  32  current mepc (mret target)
mie_global  out  1  mstatus.MIE

Behaviour:
- Reset (rst high at clk edge): mstatus = 0x00000008 (MIE=1); mtvec = MTVEC_RESET; all other CSRs, counters and input sync flops = 0; irq_req = 0. Reset overrides every concurrent event.
- Implemented addresses: mstatus 0x300, misa 0x301 (reads 0x40000100, writes ignored), mie 0x304, mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mstatush 0x310 (reads 0).
- Read-only IDs 0xF11–0xF14 read 0.
- csr_illegal = csr_req & op≠00 & (address unimplemented, or address[11:10]==11 with a write).
- A write is RW, or RS/RC with wdata≠0. An illegal access changes no state.
- RW: new = wdata. RS: new = old | wdata. RC: new = old & ~wdata. The write takes effect at the next edge; csr_rdata shows the pre-write value.
- WARL rules:
  - mstatus: only MIE (bit 3) and MPIE (bit 7) are writable.
  - mepc[1:0] = 0.
  - mtvec[1:0] = 01 only if VECTORED_EN and written 01, else 00.
  - mie: only bits 3, 7, 11 and 16+i are writable.
  - mip: read-only, writes ignored.
  - mcountinhibit: only bits 0 (CY) and 2 (IR) are writable.
- mip: bits 3/7/11/16+i = inputs registered through one flop. irq_req is registered: irq_req(t+1) = MIE & |(mip & mie) at t, so 2 cycles from input rising to irq_req.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > fast lines, lowest index first (code 16+i).
- Counters:
  - mcycle increments every cycle unless CY is set.
  - minstret increments when instr_retire is set unless IR is set.
  - Both wrap to 0 at 2^COUNTER_W.
  - A CSR write to a counter half wins over the increment that cycle; the other half holds.
- Trap priority in one cycle: exc_valid > irq_ack > mret > CSR write. A CSR write in the same cycle as a trap is discarded.
- Exception:
  - mepc = exc_pc & ~3; mcause = {0, exc_cause}; mtval = exc_tval.
  - MPIE = MIE; MIE = 0.
  - trap_vector = mtvec base.
- irq_ack: does nothing when irq_req = 0. Otherwise:
  - mepc = irq_pc & ~3; mcause = {1, code} for the highest-priority pending interrupt; mtval = 0.
  - MPIE = MIE; MIE = 0.
  - irq_req drops the next cycle.
- trap_vector is combinational from current state:
  - Vectored: base + 4·code of the highest pending enabled interrupt.
  - Otherwise: base.
- mret: MIE = MPIE; MPIE = 1. mepc_o remains valid that cycle.

Test Plan:
- Reset, read 0x300 and 0xB00 → 0x00000008, then 0; after 10 idle cycles mcycle reads 10; RS 0x320 wdata=1 → mcycle freezes.
- RS mie=0x800, raise irq_ext → irq_req high 2 cycles later; irq_ack with irq_pc=0x104 → mcause=0x8000000B, mepc=0x104, MIE=0, MPIE=1; then mret → MIE=1.
- mtvec=0x1001 (vectored), irq_timer and irq_fast[0] pending and enabled → trap_vector=0x101C (MTI wins over the fast line).
- exc_valid (cause 2, pc 0x203, tval 0xDEAD) with irq_ack and a CSR write to mscratch in the same cycle → mcause=2, mepc=0x200, mtval=0xDEAD, mscratch unchanged.
- Write 0xF11, and read 0x7C0 → csr_illegal=1 in both cases, no state change; RC mcycle with wdata=0 → csr_illegal=0, no write.
- Write mcycle=0xFFFFFFFF, mcycleh=0 → wraps to mcycleh=1 the following cycle; assert rst mid-count → all counters read 0.
